// File: rtl/dct2d_stream_if.sv
// Streaming handshake bundle for the 2-D DCT: row beats in, column beats out.
// master = block feeding rows / taking columns, slave = the DCT engine.
interface dct2d_stream_if #(
    parameter int N            = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 12,
    parameter int TAG_BITWIDTH = 2
);
    logic                      i_valid;
    logic                      o_ready;
    logic [N*IN_BITWIDTH-1:0]  i_row;
    logic [TAG_BITWIDTH-1:0]   i_tag;
    logic                      o_valid;
    logic                      i_ready;
    logic [N*OUT_BITWIDTH-1:0] o_col;
    logic [TAG_BITWIDTH-1:0]   o_tag;
    logic                      o_last;

    modport master (
        output i_valid, i_row, i_tag, i_ready,
        input  o_ready, o_valid, o_col, o_tag, o_last
    );

    modport slave (
        input  i_valid, i_row, i_tag, i_ready,
        output o_ready, o_valid, o_col, o_tag, o_last
    );
endinterface

// File: rtl/dct2d_stream.sv
// Streaming separable 2-D forward DCT. A row pass writes each accepted row into
// one bank of a ping-pong transpose buffer; a column pass drains the other bank
// into a registered output, one column per beat.
//
// Bank state table (one per bank):
//   state | meaning
//   EMPTY | free, may start receiving rows of a new block
//   FILL  | rows 0..N-2 of a block are being written
//   FULL  | all N rows written, waiting for / under column drain
module dct2d_stream #(
    parameter int N            = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int LEVEL_SHIFT  = 1,
    parameter int COEF_FRAC    = 14,
    parameter int INT_BITWIDTH = 14,
    parameter int OUT_BITWIDTH = 12,
    parameter int TAG_BITWIDTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    dct2d_stream_if.slave io
);
    localparam int  LOGN = $clog2(N);
    localparam int  CW   = COEF_FRAC + 1;
    localparam int  RPW  = IN_BITWIDTH + 1 + CW;
    localparam int  RSW  = RPW + LOGN;
    localparam int  CPW  = INT_BITWIDTH + CW;
    localparam int  CSW  = CPW + LOGN;
    localparam real PI   = 3.14159265358979323846;
    localparam logic signed [IN_BITWIDTH:0] MID = (IN_BITWIDTH + 1)'(1 << (IN_BITWIDTH - 1));

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_state_t;

    logic signed [CW-1:0]           coef [N][N];
    logic signed [IN_BITWIDTH:0]    xs [N];
    logic signed [INT_BITWIDTH-1:0] rrow [N];
    logic signed [RPW-1:0]          rprod;
    logic signed [RSW-1:0]          racc;
    logic signed [CPW-1:0]          cprod;
    logic signed [CSW-1:0]          cacc;
    logic [N*OUT_BITWIDTH-1:0]      col_flat;

    logic signed [INT_BITWIDTH-1:0] tbuf [2][N][N];
    logic [TAG_BITWIDTH-1:0]        tag_bank [2];

    bank_state_t bank_state [2];
    bank_state_t bank_nxt [2];
    logic        fill_ptr, fill_nxt;
    logic        drain_ptr, drain_nxt;
    logic [LOGN-1:0] in_cnt, in_cnt_nxt;
    logic [LOGN-1:0] out_cnt, out_cnt_nxt;
    logic        ready_q, ready_nxt;
    logic        accept, load_out;

    logic                      valid_q;
    logic [N*OUT_BITWIDTH-1:0] col_q;
    logic [TAG_BITWIDTH-1:0]   tag_q;
    logic                      last_q;

    // Cosine table is fixed at elaboration; round half away from zero.
    for (genvar u = 0; u < N; u++) begin : g_coef_u
        for (genvar x = 0; x < N; x++) begin : g_coef_x
            localparam real SCALE = (u == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
            localparam real VAL   = SCALE * $cos((2.0 * x + 1.0) * u * PI / (2.0 * N))
                                    * (2.0 ** COEF_FRAC);
            localparam int  IVAL  = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
            assign coef[u][x] = CW'(IVAL);
        end
    end

    // Round-half-up by COEF_FRAC bits, then clamp to a signed w-bit range.
    function automatic longint rnd_sat(input longint s, input int w);
        longint r;
        longint hi;
        longint lo;
        r  = (s + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

    assign accept   = io.i_valid & ready_q;
    assign load_out = (bank_state[drain_ptr] == FULL) & (~valid_q | io.i_ready);

    // Row pass: level shift the incoming beat and transform it in the acceptance cycle.
    always_comb begin
        xs    = '{default: '0};
        rrow  = '{default: '0};
        rprod = '0;
        racc  = '0;
        for (int x = 0; x < N; x++) begin
            if (LEVEL_SHIFT != 0) begin
                xs[x] = $signed({1'b0, io.i_row[x*IN_BITWIDTH +: IN_BITWIDTH]}) - MID;
            end else begin
                xs[x] = $signed({io.i_row[x*IN_BITWIDTH + IN_BITWIDTH - 1],
                                 io.i_row[x*IN_BITWIDTH +: IN_BITWIDTH]});
            end
        end
        for (int u = 0; u < N; u++) begin
            racc = '0;
            for (int x = 0; x < N; x++) begin
                rprod = RPW'(xs[x]) * RPW'(coef[u][x]);
                racc  = racc + RSW'(rprod);
            end
            rrow[u] = INT_BITWIDTH'(rnd_sat(longint'(racc), INT_BITWIDTH));
        end
    end

    // Column pass: transform column out_cnt of the drain bank.
    always_comb begin
        cprod    = '0;
        cacc     = '0;
        col_flat = '0;
        for (int v = 0; v < N; v++) begin
            cacc = '0;
            for (int y = 0; y < N; y++) begin
                cprod = CPW'(coef[v][y]) * CPW'(tbuf[drain_ptr][y][out_cnt]);
                cacc  = cacc + CSW'(cprod);
            end
            col_flat[v*OUT_BITWIDTH +: OUT_BITWIDTH] =
                OUT_BITWIDTH'(rnd_sat(longint'(cacc), OUT_BITWIDTH));
        end
    end

    // Bank sequencing next state; fill and drain always touch different banks.
    always_comb begin
        bank_nxt    = bank_state;
        fill_nxt    = fill_ptr;
        drain_nxt   = drain_ptr;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        if (accept) begin
            if (in_cnt == '0) begin
                bank_nxt[fill_ptr] = FILL;
            end
            if (in_cnt == LOGN'(N - 1)) begin
                bank_nxt[fill_ptr] = FULL;
                fill_nxt           = ~fill_ptr;
                in_cnt_nxt         = '0;
            end else begin
                in_cnt_nxt = in_cnt + 1'b1;
            end
        end
        if (load_out) begin
            if (out_cnt == LOGN'(N - 1)) begin
                bank_nxt[drain_ptr] = EMPTY;
                drain_nxt           = ~drain_ptr;
                out_cnt_nxt         = '0;
            end else begin
                out_cnt_nxt = out_cnt + 1'b1;
            end
        end
        // Registered ready: looks ahead at the bank the fill pointer will point to.
        ready_nxt = (bank_nxt[fill_nxt] != FULL);
    end

    // Bank state register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            fill_ptr      <= 1'b0;
            drain_ptr     <= 1'b0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            ready_q       <= 1'b0;
        end else begin
            bank_state <= bank_nxt;
            fill_ptr   <= fill_nxt;
            drain_ptr  <= drain_nxt;
            in_cnt     <= in_cnt_nxt;
            out_cnt    <= out_cnt_nxt;
            ready_q    <= ready_nxt;
        end
    end

    // Transpose buffer and per-bank tag storage; contents are don't-care until FULL.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int u = 0; u < N; u++) begin
                tbuf[fill_ptr][in_cnt][u] <= rrow[u];
            end
            if (in_cnt == '0) begin
                tag_bank[fill_ptr] <= io.i_tag;
            end
        end
    end

    // Output register: loads a new column when empty or when the current one is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            tag_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_out) begin
            valid_q <= 1'b1;
            col_q   <= col_flat;
            tag_q   <= tag_bank[drain_ptr];
            last_q  <= (out_cnt == LOGN'(N - 1));
        end else if (io.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign io.o_ready = ready_q;
    assign io.o_valid = valid_q;
    assign io.o_col   = col_q;
    assign io.o_tag   = tag_q;
    assign io.o_last  = last_q;

endmodule
